// File: rtl/req_pend.sv
// req_pend: pending-request tracker with a grant/issue handshake.
// Keeps one pending bit per slot, takes one-hot grants from an external
// priority selector, checks that each grant is legal, and presents the
// granted slot index on a valid/ready issue port. Illegal grants leave
// the state untouched and raise a one-cycle error pulse.
// Optional build macro REQ_PEND_AGE_EN adds a saturating age counter per
// slot and drives o_starve from it; without the macro o_starve is 0.
module req_pend #(
  parameter int W     = 8,
  parameter int AGE_W = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [W-1:0]         i_set,
  output logic [W-1:0]         o_pend,
  input  logic                 i_gnt_vld,
  input  logic [W-1:0]         i_gnt,
  output logic                 o_gnt_rdy,
  output logic                 o_issue_vld,
  output logic [$clog2(W)-1:0] o_issue_id,
  input  logic                 i_issue_rdy,
  output logic                 o_err,
  output logic [W-1:0]         o_starve
);

  localparam int IDW = $clog2(W);

  // Parameter range checks at elaboration time
  if (W < 2 || W > 64) begin : g_bad_w
    $error("req_pend: W must be in 2..64");
  end
  if (AGE_W < 1 || AGE_W > 8) begin : g_bad_age_w
    $error("req_pend: AGE_W must be in 1..8");
  end

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [W-1:0] v);
    return (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  // Binary index of the set bit of a one-hot vector.
  function automatic logic [IDW-1:0] enc_onehot(input logic [W-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) r = IDW'(i);
    end
    return r;
  endfunction

  // Saturating increment used by the age counters.
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  logic [W-1:0]   pend_p1;
  logic           vld_p1;
  logic [IDW-1:0] id_p1;
  logic           err_p1;

  logic           gnt_acc_p0;
  logic           gnt_legal_p0;
  logic [W-1:0]   clr_p0;
  logic           issue_hs_p0;

  // A grant may be taken whenever the issue slot is empty or draining now.
  assign o_gnt_rdy   = !vld_p1 | i_issue_rdy;
  assign issue_hs_p0 = vld_p1 & i_issue_rdy;

  // Stage p0: qualify the incoming grant against the current pending set.
  always_comb begin
    gnt_acc_p0   = i_gnt_vld & o_gnt_rdy;
    gnt_legal_p0 = gnt_acc_p0 & is_onehot(i_gnt) & (|(i_gnt & pend_p1));
    clr_p0       = gnt_legal_p0 ? i_gnt : '0;
  end

  // Stage p1: pending vector; a new request wins over a same-cycle clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pend_p1 <= '0;
    else         pend_p1 <= (pend_p1 & ~clr_p0) | i_set;
  end

  // Issue valid: loads on a legal grant, drops on a handshake with no refill.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)           vld_p1 <= 1'b0;
    else if (gnt_legal_p0) vld_p1 <= 1'b1;
    else if (issue_hs_p0)  vld_p1 <= 1'b0;
  end

  // Issue index: replaced only by a legal grant, otherwise held.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)           id_p1 <= '0;
    else if (gnt_legal_p0) id_p1 <= enc_onehot(i_gnt);
  end

  // Error pulse: one cycle after any accepted grant that was not legal.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_p1 <= 1'b0;
    else         err_p1 <= gnt_acc_p0 & ~gnt_legal_p0;
  end

  assign o_pend      = pend_p1;
  assign o_issue_vld = vld_p1;
  assign o_issue_id  = id_p1;
  assign o_err       = err_p1;

`ifdef REQ_PEND_AGE_EN
  logic [AGE_W-1:0] age_p1 [W];

  // Age counters: count cycles a slot has been pending, reset when granted or idle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < W; i++) age_p1[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!pend_p1[i] || clr_p0[i]) age_p1[i] <= '0;
        else                          age_p1[i] <= sat_inc(age_p1[i]);
      end
    end
  end

  // Starvation flag follows counter saturation directly.
  always_comb begin
    o_starve = '0;
    for (int i = 0; i < W; i++) o_starve[i] = &age_p1[i];
  end
`else
  assign o_starve = '0;
`endif

endmodule

// File: doc/req_pend.md
REQ_PEND -- requirements
Module: req_pend

Interface
REQ-001 Parameter W, default 8, SHALL give the number of request slots (legal range 2..64).
REQ-002 Parameter AGE_W, default 4, SHALL give the age-counter width per slot (legal range 1..8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_set  input  W  SHALL carry per-slot new-request pulses (multi-hot legal).
REQ-006 o_pend  output  W  SHALL expose the registered pending-request vector (drives an external priority selector).
REQ-007 i_gnt_vld  input  1  SHALL qualify i_gnt.
REQ-008 i_gnt  input  W  SHALL carry the one-hot grant returned by the selector.
REQ-009 o_gnt_rdy  output  1  SHALL indicate a grant can be accepted this cycle.
REQ-010 o_issue_vld  output  1  SHALL indicate o_issue_id is valid.
REQ-011 o_issue_id  output  $clog2(W)  SHALL be the encoded index of the issued slot.
REQ-012 i_issue_rdy  input  1  SHALL indicate downstream accepts the issue this cycle.
REQ-013 o_err  output  1  SHALL pulse for one cycle on a rejected grant.
REQ-014 o_starve  output  W  SHALL flag slots whose age counter is saturated.

Function
REQ-015 Grant acceptance SHALL occur when i_gnt_vld & o_gnt_rdy; o_gnt_rdy = !o_issue_vld | i_issue_rdy (combinational).
REQ-016 An accepted grant SHALL be legal only if i_gnt is exactly one-hot and its bit is set in o_pend.
REQ-017 A legal accepted grant SHALL clear that o_pend bit at the next edge and load o_issue_vld=1, o_issue_id=index of the set bit at the same edge (1-cycle latency).
REQ-018 An illegal accepted grant (zero, multi-hot, or non-pending bit) SHALL change no pend/issue state and SHALL assert o_err for exactly the following cycle.
REQ-019 o_pend next SHALL equal (o_pend & ~clear) | i_set; i_set on a bit being cleared the same cycle SHALL leave the bit set (set wins).
REQ-020 i_set on an already-pending bit SHALL be absorbed with no further effect (idempotent).
REQ-021 o_issue_vld SHALL remain high with o_issue_id stable until i_issue_rdy; issue handshake with no new legal grant SHALL deassert o_issue_vld next edge.
REQ-022 Issue handshake and a new legal grant in the same cycle SHALL replace o_issue_id with no bubble (back-to-back throughput of one per cycle).
REQ-023 With i_gnt_vld low, i_gnt SHALL be ignored entirely.

Reset
REQ-024 On arst_n low, o_pend, o_issue_vld, o_issue_id, o_err, o_starve and all age counters SHALL go to 0 immediately, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL discard all pending requests and any unissued grant; no issue SHALL appear after deassertion until a new set and grant occur.
REQ-026 First state update after deassertion SHALL occur on the first rising clk edge with arst_n high.

Configuration
REQ-027 Macro REQ_PEND_AGE_EN defined: each slot SHALL have an AGE_W-bit counter incrementing every cycle its o_pend bit is 1, saturating at 2^AGE_W-1, cleared to 0 when the bit is granted or not pending; o_starve[i] SHALL be 1 while counter i is saturated.
REQ-028 Macro REQ_PEND_AGE_EN undefined: no age counters SHALL be instantiated and o_starve SHALL be tied to 0; all other behaviour identical.

Verification
REQ-029 W=8: reset, i_set=8'h24 one cycle -> next cycle o_pend=8'h24, o_issue_vld=0, o_err=0.
REQ-030 o_pend=8'h24, i_gnt_vld=1, i_gnt=8'h20, i_issue_rdy=1 -> next cycle o_pend=8'h04, o_issue_vld=1, o_issue_id=5.
REQ-031 o_issue_vld=1, i_issue_rdy=0, i_gnt_vld=1 -> o_gnt_rdy=0, o_pend unchanged, o_issue_id held.
REQ-032 o_pend=8'h04, i_gnt=8'h0C with i_gnt_vld=1 -> o_err=1 next cycle only, o_pend stays 8'h04, o_issue_vld unchanged.
REQ-033 o_pend=8'h04, i_set=8'h04 and legal grant 8'h04 same cycle -> o_pend=8'h04, o_issue_id=2.
REQ-034 REQ_PEND_AGE_EN, AGE_W=4: bit 0 pending, never granted, 15 cycles -> o_starve=8'h01; grant bit 0 -> o_starve=0 next cycle; arst_n pulse mid-run -> all outputs 0 at once.
